// File: rtl/divider_control.sv
// Sequencer for an 8-bit restoring divider datapath: load, eight shift/trial-subtract
// pairs, then a completion pulse; a zero divisor short-circuits to an error pulse.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet, sel holds
// LOAD  | divisor/dividend registers loaded, iteration count cleared
// SHIFT | remainder:quotient shifted left, 0 enters the quotient LSB
// TEST  | trial subtract; commit with quotient bit 1 unless the result is negative
// DONE  | one-cycle completion pulse
// ERR   | one-cycle divide-by-zero pulse, coincident with done
module divider_control (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_divzero,
  input  logic       i_sign,
  output logic       o_load,
  output logic       o_add,
  output logic       o_shift,
  output logic       o_inbit,
  output logic [1:0] o_sel,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_TEST  = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [1:0] SEL_LOAD   = 2'b10;
  localparam logic [1:0] SEL_COMMIT = 2'b01;
  localparam logic [1:0] SEL_HOLD   = 2'b11;

  state_t     r_state;
  logic [2:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) r_state <= i_divzero ? S_ERR : S_LOAD;
        end
        S_LOAD: begin
          r_cnt   <= 3'd0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: r_state <= S_TEST;
        S_TEST: begin
          // cnt stops at 7 so it never wraps inside one divide
          if (r_cnt == 3'd7) begin
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 3'd1;
            r_state <= S_SHIFT;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode state (and sign in TEST) so an async reset quiets them at once.
  always_comb begin
    o_load  = 1'b0;
    o_add   = 1'b0;
    o_shift = 1'b0;
    o_inbit = 1'b0;
    o_sel   = SEL_HOLD;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    o_err   = 1'b0;
    case (r_state)
      S_LOAD: begin
        o_load = 1'b1;
        o_sel  = SEL_LOAD;
        o_busy = 1'b1;
      end
      S_SHIFT: begin
        o_shift = 1'b1;
        o_busy  = 1'b1;
      end
      S_TEST: begin
        o_add   = 1'b1;
        o_busy  = 1'b1;
        o_inbit = ~i_sign;
        o_sel   = i_sign ? SEL_HOLD : SEL_COMMIT;
      end
      S_DONE: o_done = 1'b1;
      S_ERR: begin
        o_done = 1'b1;
        o_err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_divider_control.sv
// Scoreboard bench for divider_control: stimulus queues expected completions, a
// negedge monitor pops them on done and checks timing, pulse counts and results.
module tb_divider_control;

  logic       clk;
  logic       i_reset;
  logic       i_start;
  logic       i_divzero;
  logic       w_sign;
  logic       o_load;
  logic       o_add;
  logic       o_shift;
  logic       o_inbit;
  logic [1:0] o_sel;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  divider_control dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_start   (i_start),
    .i_divzero (i_divzero),
    .i_sign    (w_sign),
    .o_load    (o_load),
    .o_add     (o_add),
    .o_shift   (o_shift),
    .o_inbit   (o_inbit),
    .o_sel     (o_sel),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Restoring-division datapath driven by the controller outputs.
  logic       use_dp;
  logic       sign_force;
  logic [7:0] dp_dividend;
  logic [7:0] dp_divisor;
  logic [8:0] dp_r;
  logic [7:0] dp_q;
  logic [7:0] dp_d;
  logic       dp_sign;

  assign dp_sign = (dp_r < {1'b0, dp_d});
  assign w_sign  = use_dp ? dp_sign : sign_force;

  always @(posedge clk) begin
    if (o_load && o_sel == 2'b10) begin
      dp_d <= dp_divisor;
      dp_q <= dp_dividend;
      dp_r <= 9'd0;
    end else if (o_shift) begin
      {dp_r, dp_q} <= {dp_r[7:0], dp_q, o_inbit};
    end else if (o_add && o_sel == 2'b01) begin
      dp_r    <= dp_r - {1'b0, dp_d};
      dp_q[0] <= o_inbit;
    end
  end

  typedef struct {
    string name;
    int    done_cyc;
    int    err;
    int    chk_dp;
    int    quot;
    int    rem;
    int    n_load;
    int    n_shift;
    int    n_add;
    int    n_busy;
  } exp_t;

  exp_t sb[$];
  int   last_s;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input string nm, input int done_cyc, input int dz,
                              input int dp, input int q, input int r);
    exp_t e;
    e.name     = nm;
    e.done_cyc = done_cyc;
    e.err      = dz;
    e.chk_dp   = dp;
    e.quot     = q;
    e.rem      = r;
    e.n_load   = dz ? 0 : 1;
    e.n_shift  = dz ? 0 : 8;
    e.n_add    = dz ? 0 : 8;
    e.n_busy   = dz ? 0 : 17;
    return e;
  endfunction

  task automatic check_idle(input string nm);
    chk(nm, int'({o_load, o_add, o_shift, o_inbit, o_sel, o_busy, o_done, o_err}),
        int'(9'b0_0_0_0_11_0_0_0));
  endtask

  // Caller is in the low clock phase; start is sampled by the next rising edge.
  task automatic launch(input string nm, input bit dz, input bit dp, input int q, input int r);
    i_start   = 1'b1;
    i_divzero = dz;
    @(posedge clk);
    #1;
    last_s    = cyc;
    i_start   = 1'b0;
    i_divzero = 1'b0;
    sb.push_back(mk(nm, dz ? last_s : last_s + 17, int'(dz), int'(dp), q, r));
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    chk("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: per-cycle control legality plus per-operation scoreboard on done.
  int a_load, a_shift, a_add, a_busy;
  initial begin
    a_load = 0; a_shift = 0; a_add = 0; a_busy = 0;
    forever begin
      @(negedge clk);
      if (i_reset) begin
        a_load = 0; a_shift = 0; a_add = 0; a_busy = 0;
        continue;
      end
      a_load  += int'(o_load);
      a_shift += int'(o_shift);
      a_add   += int'(o_add);
      a_busy  += int'(o_busy);
      chk("ctl_onehot", ($countones({o_load, o_shift, o_add}) > 1) ? 1 : 0, 0);
      if (o_load)  chk("load_sel", int'(o_sel), 2);
      if (o_shift) begin
        chk("shift_sel", int'(o_sel), 3);
        chk("shift_inbit", int'(o_inbit), 0);
      end
      if (o_add) begin
        chk("test_sel", int'(o_sel), w_sign ? 3 : 1);
        chk("test_inbit", int'(o_inbit), w_sign ? 0 : 1);
      end
      if (o_err && !o_done) chk("err_without_done", 1, 0);
      if (o_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", cyc, -1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_done_cyc"}, cyc, e.done_cyc);
          chk({e.name, "_err"}, int'(o_err), e.err);
          chk({e.name, "_busy_after"}, int'(o_busy), 0);
          chk({e.name, "_n_load"}, a_load, e.n_load);
          chk({e.name, "_n_shift"}, a_shift, e.n_shift);
          chk({e.name, "_n_add"}, a_add, e.n_add);
          chk({e.name, "_n_busy"}, a_busy, e.n_busy);
          if (e.chk_dp != 0) begin
            chk({e.name, "_quot"}, int'(dp_q), e.quot);
            chk({e.name, "_rem"}, int'(dp_r), e.rem);
          end
        end
        a_load = 0; a_shift = 0; a_add = 0; a_busy = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_divzero  = 1'b0;
    use_dp     = 1'b0;
    sign_force = 1'b0;
    dp_dividend = 8'd0;
    dp_divisor  = 8'd0;
    repeat (2) @(posedge clk);
    #1 check_idle("reset_state");
    @(negedge clk);
    #2 i_reset = 1'b0;

    // Negative trial every time; a stray start+divzero mid-divide must be ignored.
    sign_force = 1'b1;
    @(negedge clk); #1;
    launch("sign1", 1'b0, 1'b0, 0, 0);
    repeat (5) @(negedge clk);
    #1 i_start = 1'b1; i_divzero = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0; i_divzero = 1'b0;
    drain(40);

    sign_force = 1'b0;
    @(negedge clk); #1;
    launch("sign0", 1'b0, 1'b0, 0, 0);
    drain(40);

    use_dp = 1'b1;
    dp_dividend = 8'd100; dp_divisor = 8'd7;
    @(negedge clk); #1;
    launch("dp_100_7", 1'b0, 1'b1, 14, 2);
    drain(40);
    dp_dividend = 8'd255; dp_divisor = 8'd1;
    @(negedge clk); #1;
    launch("dp_255_1", 1'b0, 1'b1, 255, 0);
    drain(40);
    dp_dividend = 8'd200; dp_divisor = 8'd13;
    @(negedge clk); #1;
    launch("dp_200_13", 1'b0, 1'b1, 15, 5);
    drain(40);

    @(negedge clk); #1;
    launch("divzero", 1'b1, 1'b0, 0, 0);
    drain(10);

    // Abort in cycle 9: outputs go idle at once, aborted op never completes,
    // and a start presented as reset releases is taken on the first edge.
    dp_dividend = 8'd100; dp_divisor = 8'd7;
    @(negedge clk); #1;
    launch("aborted", 1'b0, 1'b0, 0, 0);
    repeat (9) @(negedge clk);
    #2 i_reset = 1'b1;
    sb.delete();
    #1 check_idle("reset_async");
    @(negedge clk);
    #2 i_reset = 1'b0;
    launch("after_reset", 1'b0, 1'b1, 14, 2);
    drain(40);

    // start held for 40 edges: divides sampled in cycles 0, 19 and 38.
    use_dp = 1'b0;
    sign_force = 1'b1;
    @(negedge clk); #1;
    i_start = 1'b1;
    @(posedge clk);
    #1 last_s = cyc;
    sb.push_back(mk("held_1", last_s + 17, 0, 0, 0, 0));
    sb.push_back(mk("held_2", last_s + 36, 0, 0, 0, 0));
    sb.push_back(mk("held_3", last_s + 55, 0, 0, 0, 0));
    repeat (39) @(posedge clk);
    #1 i_start = 1'b0;
    drain(60);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
